// File: rtl/pong_pkg.sv
// ---------------------------------------------------------------------------
// pong_pkg
// Shared definitions for the Pong game sequencer and the text generator.
//   state_e          : game state codes, also exported as the debug state
//   TEXT_*           : overlay select codes consumed by the text generator
//   text_for_state() : maps a game state to its overlay select
// ---------------------------------------------------------------------------
package pong_pkg;

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_e;

  localparam logic [1:0] TEXT_NONE  = 2'b00;
  localparam logic [1:0] TEXT_TITLE = 2'b01;
  localparam logic [1:0] TEXT_READY = 2'b10;
  localparam logic [1:0] TEXT_OVER  = 2'b11;

  function automatic logic [1:0] text_for_state(input state_e s);
    logic [1:0] sel;
    case (s)
      ST_NEWGAME: sel = TEXT_TITLE;
      ST_PLAY:    sel = TEXT_NONE;
      ST_NEWBALL: sel = TEXT_READY;
      default:    sel = TEXT_OVER;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl_if
// Bundles the sequencer's event inputs and game outputs.
//   master : the side producing frame_tick / btn / hit / miss
//            (graphics datapath + debouncers, or a testbench)
//   slave  : the game sequencer itself
// Signals:
//   frame_tick  one-clk pulse per frame (start of vertical blanking)
//   btn[1:0]    debounced paddle buttons, level
//   hit, miss   one-clk pulses from the graphics datapath
//   gra_still   1 = graphics frozen, ball held at start position
//   ball_reset  one-clk pulse requesting ball re-centre
//   score_tens, score_ones  2-digit BCD score
//   balls_left  remaining balls
//   text_sel    overlay select
//   game_state  debug state code
// ---------------------------------------------------------------------------
interface pong_game_ctrl_if;

  logic       frame_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic       gra_still;
  logic       ball_reset;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] balls_left;
  logic [1:0] text_sel;
  logic [1:0] game_state;

  modport master (
    output frame_tick, btn, hit, miss,
    input  gra_still, ball_reset, score_tens, score_ones,
    input  balls_left, text_sel, game_state
  );

  modport slave (
    input  frame_tick, btn, hit, miss,
    output gra_still, ball_reset, score_tens, score_ones,
    output balls_left, text_sel, game_state
  );

endinterface

// File: rtl/pong_game_ctrl_bcd_counter2.sv
// ---------------------------------------------------------------------------
// bcd_counter2
// Two-digit BCD up-counter, 00..99 wrapping back to 00.
// Ports:
//   clk, reset  clock and asynchronous active-high reset (clears to 00)
//   clr         synchronous clear to 00, wins over inc
//   inc         count up by one
//   tens, ones  BCD digits, always within 0-9
// ---------------------------------------------------------------------------
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  logic [3:0] tens_q, ones_q;

  // Ones digit carries into tens at 9; tens wraps to 0 at 9 so 99 -> 00.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (clr) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else if (inc) begin
      if (ones_q == 4'd9) begin
        ones_q <= 4'd0;
        tens_q <= (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
      end else begin
        ones_q <= ones_q + 4'd1;
      end
    end
  end

  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// pong_game_ctrl
// Game sequencer for Pong: runs the NEWGAME / PLAY / NEWBALL / OVER flow,
// keeps the score and ball count, freezes the graphics between rallies and
// selects the text overlay.
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    pong_game_ctrl_if.slave (events in, game status out)
// Parameters:
//   BALLS         balls per game
//   TIMER_FRAMES  frames waited in NEWBALL and OVER
//   TIMER_W       timer width, TIMER_FRAMES must fit
// ---------------------------------------------------------------------------
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int BALLS        = 3,
  parameter int TIMER_FRAMES = 120,
  parameter int TIMER_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [1:0]         BALLS_LOAD = 2'(BALLS);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_FRAMES);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         balls_q, balls_d;
  logic [1:0]         btn_q;
  logic               ball_reset_q, ball_reset_d;
  logic               gra_still_q;
  logic [1:0]         text_sel_q;
  logic               start;
  logic               score_clr, score_inc;
  logic [3:0]         tens_w, ones_w;

  // Only a fresh press counts, so a button held through a state change
  // cannot kick off play.
  assign start = |(bus.btn & ~btn_q);

  // Next-state logic for the game flow, ball counter and frame timer.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    balls_d      = balls_q;
    ball_reset_d = 1'b0;
    score_clr    = 1'b0;
    score_inc    = 1'b0;
    case (state_q)
      ST_NEWGAME: begin
        balls_d = BALLS_LOAD;
        if (start) begin
          state_d      = ST_PLAY;
          ball_reset_d = 1'b1;
          score_clr    = 1'b1;
        end
      end
      ST_PLAY: begin
        // A miss swallows a hit arriving in the same cycle.
        if (bus.miss) begin
          timer_d = TIMER_LOAD;
          if (balls_q > 2'd1) begin
            balls_d = balls_q - 2'd1;
            state_d = ST_NEWBALL;
          end else begin
            balls_d = 2'd0;
            state_d = ST_OVER;
          end
        end else if (bus.hit) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_q == '0) begin
          if (start) begin
            state_d      = ST_PLAY;
            ball_reset_d = 1'b1;
          end
        end else if (bus.frame_tick) begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
      default: begin
        // Score stays on screen after returning to NEWGAME; it is only
        // cleared when the next game actually starts.
        if (timer_q == '0) begin
          state_d = ST_NEWGAME;
          balls_d = BALLS_LOAD;
        end else if (bus.frame_tick) begin
          timer_d = timer_q - TIMER_ONE;
        end
      end
    endcase
  end

  // State and registered outputs; the overlay and freeze flags are decoded
  // from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_NEWGAME;
      timer_q      <= '0;
      balls_q      <= BALLS_LOAD;
      btn_q        <= 2'b00;
      ball_reset_q <= 1'b0;
      gra_still_q  <= 1'b1;
      text_sel_q   <= TEXT_TITLE;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      balls_q      <= balls_d;
      btn_q        <= bus.btn;
      ball_reset_q <= ball_reset_d;
      gra_still_q  <= (state_d != ST_PLAY);
      text_sel_q   <= text_for_state(state_d);
    end
  end

  bcd_counter2 u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .tens  (tens_w),
    .ones  (ones_w)
  );

  assign bus.gra_still  = gra_still_q;
  assign bus.ball_reset = ball_reset_q;
  assign bus.score_tens = tens_w;
  assign bus.score_ones = ones_w;
  assign bus.balls_left = balls_q;
  assign bus.text_sel   = text_sel_q;
  assign bus.game_state = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pong_game_ctrl
// Self-checking bench for pong_game_ctrl. A game-level model (integer score,
// ball count and frame countdown) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pong_game_ctrl;

  logic clk;
  logic reset;

  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .BALLS        (3),
    .TIMER_FRAMES (120),
    .TIMER_W      (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Game model: mode 0=new game, 1=play, 2=waiting for ball, 3=over.
  int         mMode;
  int         mScore;
  int         mBalls;
  int         mTimer;
  logic [1:0] mPrevBtn;
  bit         mBallReset;

  function automatic void modelReset();
    mMode      = 0;
    mScore     = 0;
    mBalls     = 3;
    mTimer     = 0;
    mPrevBtn   = 2'b00;
    mBallReset = 1'b0;
  endfunction

  function automatic void modelStep(bit fb, logic [1:0] b, bit h, bit m);
    bit pressed;
    pressed    = |(b & ~mPrevBtn);
    mPrevBtn   = b;
    mBallReset = 1'b0;
    case (mMode)
      0: begin
        if (pressed) begin
          mMode      = 1;
          mScore     = 0;
          mBallReset = 1'b1;
        end
      end
      1: begin
        if (m) begin
          mBalls = mBalls - 1;
          mTimer = 120;
          mMode  = (mBalls == 0) ? 3 : 2;
        end else if (h) begin
          mScore = (mScore + 1) % 100;
        end
      end
      2: begin
        if (mTimer == 0) begin
          if (pressed) begin
            mMode      = 1;
            mBallReset = 1'b1;
          end
        end else if (fb) begin
          mTimer = mTimer - 1;
        end
      end
      default: begin
        if (mTimer == 0) begin
          mMode  = 0;
          mBalls = 3;
        end else if (fb) begin
          mTimer = mTimer - 1;
        end
      end
    endcase
  endfunction

  // {state, gra_still, ball_reset, tens, ones, balls_left, text_sel}
  function automatic logic [15:0] expVec();
    logic [1:0] txt;
    case (mMode)
      0:       txt = 2'b01;
      1:       txt = 2'b00;
      2:       txt = 2'b10;
      default: txt = 2'b11;
    endcase
    return {2'(mMode), (mMode != 1), mBallReset, 4'(mScore / 10),
            4'(mScore % 10), 2'(mBalls), txt};
  endfunction

  function automatic logic [15:0] actVec();
    return {bus.game_state, bus.gra_still, bus.ball_reset, bus.score_tens,
            bus.score_ones, bus.balls_left, bus.text_sel};
  endfunction

  // Drive one cycle of inputs from a falling edge, advance the model at the
  // rising edge, and return on the next falling edge for sampling.
  task automatic applyStimulus(input bit fb, input logic [1:0] b,
                               input bit h, input bit m);
    bus.frame_tick = fb;
    bus.btn        = b;
    bus.hit        = h;
    bus.miss       = m;
    @(posedge clk);
    modelStep(fb, b, h, m);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.frame_tick = 1'b0;
    bus.btn        = 2'b00;
    bus.hit        = 1'b0;
    bus.miss       = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    @(negedge clk);
    modelReset();
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%h want=%h", actVec(), expVec());
    end
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'b00,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++;
      if (actVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL reset_idle cyc=%0d got=%h want=%h", i, actVec(), expVec());
      end
    end
    total++;
    if (actVec() !== {2'd0, 1'b1, 1'b0, 8'h00, 2'd3, 2'b01}) begin
      bad++;
      $display("[TB] FAIL reset_idle_final got=%h want=%h", actVec(),
               {2'd0, 1'b1, 1'b0, 8'h00, 2'd3, 2'b01});
    end
  endtask

  task automatic test_start();
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL start_edge got=%h want=%h", actVec(), expVec());
    end
    total++;
    if ({bus.game_state, bus.ball_reset, bus.gra_still} !== {2'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("[TB] FAIL start_pulse got=%b want=%b",
               {bus.game_state, bus.ball_reset, bus.gra_still}, {2'd1, 1'b1, 1'b0});
    end
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    total++;
    if (bus.ball_reset !== 1'b0 || actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL start_pulse_len got=%h want=%h", actVec(), expVec());
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic test_score_wrap();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'b00, 1'b1, 1'b0);
      total++;
      if (actVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL score_step hit=%0d got=%h want=%h", i + 1, actVec(), expVec());
      end
      if (i == 9) begin
        total++;
        if ({bus.score_tens, bus.score_ones} !== 8'h10) begin
          bad++;
          $display("[TB] FAIL score_carry_09_10 got=%h want=10",
                   {bus.score_tens, bus.score_ones});
        end
      end
    end
    total++;
    if ({bus.score_tens, bus.score_ones} !== 8'h00) begin
      bad++;
      $display("[TB] FAIL score_wrap_99_00 got=%h want=00", {bus.score_tens, bus.score_ones});
    end
  endtask

  task automatic test_miss_newball();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    total++;
    if ({bus.game_state, bus.balls_left, bus.text_sel} !== {2'd2, 2'd2, 2'b10}) begin
      bad++;
      $display("[TB] FAIL miss_to_newball got=%b want=%b",
               {bus.game_state, bus.balls_left, bus.text_sel}, {2'd2, 2'd2, 2'b10});
    end
    for (int t = 0; t < 120; t++) begin
      applyStimulus(1'b1, 2'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      total++;
      if (actVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL newball_wait tick=%0d got=%h want=%h", t, actVec(), expVec());
      end
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    total++;
    if (bus.game_state !== 2'd2) begin
      bad++;
      $display("[TB] FAIL newball_early_start got=%0d want=2", bus.game_state);
    end
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    total++;
    if (actVec() !== expVec() || bus.game_state !== 2'd1 || bus.ball_reset !== 1'b1) begin
      bad++;
      $display("[TB] FAIL newball_start got=%h want=%h", actVec(), expVec());
    end
  endtask

  task automatic test_hit_miss_same();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b1, 1'b1);
    total++;
    if ({bus.score_tens, bus.score_ones, bus.balls_left} !== {8'h03, 2'd1}) begin
      bad++;
      $display("[TB] FAIL hit_miss_same got=%h want=%h",
               {bus.score_tens, bus.score_ones, bus.balls_left}, {8'h03, 2'd1});
    end
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL hit_miss_model got=%h want=%h", actVec(), expVec());
    end
    for (int t = 0; t < 120; t++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL hit_miss_restart got=%h want=%h", actVec(), expVec());
    end
  endtask

  task automatic test_over();
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 2'b01, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b1);
    total++;
    if ({bus.game_state, bus.balls_left, bus.text_sel} !== {2'd3, 2'd0, 2'b11}) begin
      bad++;
      $display("[TB] FAIL over_entry got=%b want=%b",
               {bus.game_state, bus.balls_left, bus.text_sel}, {2'd3, 2'd0, 2'b11});
    end
    for (int t = 0; t < 130; t++) begin
      applyStimulus(1'($urandom_range(0, 1)) | (t < 120), 2'b01, 1'b0, 1'b0);
      total++;
      if (actVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL over_wait cyc=%0d got=%h want=%h", t, actVec(), expVec());
      end
    end
    total++;
    if ({bus.game_state, bus.balls_left, bus.score_tens, bus.score_ones} !==
        {2'd0, 2'd3, 8'h08}) begin
      bad++;
      $display("[TB] FAIL over_to_newgame_held got=%h want=%h",
               {bus.game_state, bus.balls_left, bus.score_tens, bus.score_ones},
               {2'd0, 2'd3, 8'h08});
    end
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
    applyStimulus(1'b0, 2'b01, 1'b0, 1'b0);
    total++;
    if ({bus.game_state, bus.score_tens, bus.score_ones} !== {2'd1, 8'h00}) begin
      bad++;
      $display("[TB] FAIL newgame_score_clear got=%h want=%h",
               {bus.game_state, bus.score_tens, bus.score_ones}, {2'd1, 8'h00});
    end
  endtask

  task automatic test_reset_mid();
    applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
    for (int t = 0; t < 7; t++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL reset_mid_async got=%h want=%h", actVec(), expVec());
    end
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b0);
    total++;
    if (actVec() !== expVec()) begin
      bad++;
      $display("[TB] FAIL reset_mid_after got=%h want=%h", actVec(), expVec());
    end
  endtask

  task automatic test_random();
    logic [1:0] b;
    b = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) b = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 3) == 0, b,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      total++;
      if (actVec() !== expVec()) begin
        bad++;
        $display("[TB] FAIL random cyc=%0d got=%h want=%h", i, actVec(), expVec());
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    modelReset();
    test_reset();
    test_start();
    test_score_wrap();
    test_miss_newball();
    test_hit_miss_same();
    test_over();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
